// File: rtl/bnn_argmax_classifier.sv
// bnn_argmax_classifier: streams final-layer neuron scores and registers the argmax class, score, margin and confidence flags
module bnn_argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 12,
  parameter int IDX_W       = 4,
  parameter int MIN_MARGIN  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score_data,
  input  logic               score_last,
  output logic               score_ready,
  output logic               busy,
  output logic               result_valid,
  output logic [IDX_W-1:0]   class_idx,
  output logic [SCORE_W-1:0] class_score,
  output logic [SCORE_W-1:0] margin,
  output logic               low_conf,
  output logic               err_len
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_best_idx;
  logic [SCORE_W-1:0] r_best;
  logic [SCORE_W-1:0] r_second;
  logic [IDX_W-1:0]   r_class_idx;
  logic [SCORE_W-1:0] r_class_score;
  logic [SCORE_W-1:0] r_margin;
  logic               r_low_conf;
  logic               r_err_len;
  logic               w_acc;
  logic               w_first;
  logic               w_gt_best;
  logic               w_last_cnt;
  logic               w_end;
  logic [IDX_W-1:0]   w_idx;
  logic [SCORE_W-1:0] w_best;
  logic [SCORE_W-1:0] w_second;
  logic [SCORE_W-1:0] w_margin;
  // A beat arriving alongside start belongs to the aborted vector, so it is refused
  assign score_ready  = (r_state == S_COLLECT) && !start;
  assign busy         = (r_state == S_COLLECT);
  assign result_valid = (r_state == S_DONE);
  assign class_idx    = r_class_idx;
  assign class_score  = r_class_score;
  assign margin       = r_margin;
  assign low_conf     = r_low_conf;
  assign err_len      = r_err_len;
  // Candidate best/runner-up after the current beat; strict compares keep the lowest index on ties
  always_comb begin
    w_acc      = score_valid && score_ready;
    w_first    = (r_cnt == '0);
    w_gt_best  = score_data > r_best;
    w_last_cnt = (r_cnt == IDX_W'(NUM_CLASSES - 1));
    w_end      = w_acc && (score_last || w_last_cnt);
    w_best     = (w_first || w_gt_best) ? score_data : r_best;
    w_idx      = w_first ? '0 : w_gt_best ? r_cnt : r_best_idx;
    w_second   = w_first ? '0 : w_gt_best ? r_best : (score_data > r_second) ? score_data : r_second;
    w_margin   = w_best - w_second;
  end
  // Control FSM, running best/second tracking and result capture on vector end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_best_idx    <= '0;
      r_best        <= '0;
      r_second      <= '0;
      r_class_idx   <= '0;
      r_class_score <= '0;
      r_margin      <= '0;
      r_low_conf    <= 1'b0;
      r_err_len     <= 1'b0;
    end else if (start) begin
      r_state    <= S_COLLECT;
      r_cnt      <= '0;
      r_best_idx <= '0;
      r_best     <= '0;
      r_second   <= '0;
    end else if (r_state == S_COLLECT) begin
      if (w_acc) begin
        r_best     <= w_best;
        r_second   <= w_second;
        r_best_idx <= w_idx;
        r_cnt      <= w_last_cnt ? r_cnt : r_cnt + IDX_W'(1);
      end
      if (w_end) begin
        r_state       <= S_DONE;
        r_class_idx   <= w_idx;
        r_class_score <= w_best;
        r_margin      <= w_margin;
        r_low_conf    <= w_margin < SCORE_W'(MIN_MARGIN);
        r_err_len     <= score_last ^ w_last_cnt;
      end
    end else if (r_state == S_DONE) begin
      r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_bnn_argmax_classifier.sv
// tb_bnn_argmax_classifier: directed checks of argmax, margin, length errors, gaps, restart and reset
module tb_bnn_argmax_classifier;
  logic        clk = 1'b0;
  logic        rst, start, score_valid, score_last;
  logic [11:0] score_data;
  logic        score_ready, busy, result_valid, low_conf, err_len;
  logic [3:0]  class_idx;
  logic [11:0] class_score, margin;
  int n_chk = 0;
  int n_fail = 0;
  int v1 [10] = '{5, 9, 3, 7, 2, 1, 0, 4, 8, 6};

  bnn_argmax_classifier dut (
    .clk(clk), .rst(rst), .start(start), .score_valid(score_valid),
    .score_data(score_data), .score_last(score_last), .score_ready(score_ready),
    .busy(busy), .result_valid(result_valid), .class_idx(class_idx),
    .class_score(class_score), .margin(margin), .low_conf(low_conf), .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input int d, input logic l);
    @(negedge clk);
    start = s; score_valid = v; score_data = 12'(d); score_last = l;
    #1;
  endtask

  task automatic check_result(input string tag, input int idx, input int sc, input int mg, input logic lc, input logic el);
    drive(0, 0, 0, 0);
    chk({tag, ".rv"}, result_valid, 1);
    chk({tag, ".idx"}, class_idx, idx);
    chk({tag, ".score"}, class_score, sc);
    chk({tag, ".margin"}, margin, mg);
    chk({tag, ".low_conf"}, low_conf, lc);
    chk({tag, ".err_len"}, err_len, el);
    drive(0, 0, 0, 0);
    chk({tag, ".rv_low"}, result_valid, 0);
    chk({tag, ".idx_hold"}, class_idx, idx);
  endtask

  initial begin
    rst = 1; start = 0; score_valid = 0; score_data = 0; score_last = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.ready", score_ready, 0);
    chk("rst.busy", busy, 0);
    chk("rst.rv", result_valid, 0);
    chk("rst.idx", class_idx, 0);
    chk("rst.score", class_score, 0);
    chk("rst.margin", margin, 0);
    chk("rst.flags", {low_conf, err_len}, 0);
    drive(0, 0, 0, 0);
    rst = 0;

    // Basic vector
    drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, v1[i], i == 9);
      chk("t1.busy", busy, 1);
      if (i == 9) chk("t1.ready", score_ready, 1);
    end
    check_result("t1", 1, 9, 1, 0, 0);

    // All equal: lowest index wins
    drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 7, i == 9);
    check_result("t2a", 0, 7, 0, 1, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, i == 0 ? 3 : (i < 3 ? 12 : 0), i == 9);
    check_result("t2b", 1, 12, 0, 1, 0);

    // Short vector and missing last
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, i + 1, i == 3);
    check_result("t3a", 3, 4, 1, 0, 1);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, i * 3, 0);
      if (i == 8) chk("t3b.no_early_rv", result_valid, 0);
    end
    check_result("t3b", 9, 27, 3, 0, 1);

    // Beats in IDLE are ignored; then gapped vector
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 4000, 1);
      chk("t4.idle_ready", score_ready, 0);
      chk("t4.idle_rv", result_valid, 0);
    end
    drive(1, 0, 0, 0);
    chk("t4.busy_start", busy, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, v1[i], i == 9);
      chk("t4.busy", busy, 1);
      if (i == 0) chk("t4.hold_score", class_score, 27);
      if (i == 0) chk("t4.hold_err", err_len, 1);
      if (i < 9) begin
        drive(0, 0, 4000, 1);
        chk("t4.gap_rv", result_valid, 0);
      end
    end
    check_result("t4", 1, 9, 1, 0, 0);

    // Restart mid-vector
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 100 * (i + 1), 0);
    drive(1, 1, 4000, 0);
    chk("t5.ready_forced_low", score_ready, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, i == 9 ? 4095 : 0, i == 9);
    check_result("t5", 9, 4095, 4095, 0, 0);

    // Reset mid-vector
    drive(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 50 + i, 0);
    drive(0, 0, 0, 0);
    rst = 1;
    drive(0, 0, 0, 0);
    rst = 0;
    chk("t6.busy", busy, 0);
    chk("t6.rv", result_valid, 0);
    chk("t6.score", class_score, 0);
    chk("t6.idx", class_idx, 0);
    chk("t6.margin", margin, 0);
    drive(0, 1, 9, 1);
    chk("t6.rv_after", result_valid, 0);
    chk("t6.ready", score_ready, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, v1[i], i == 9);
    check_result("t6", 1, 9, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
